// File: rtl/mem_stage_ls.sv
// mem_stage_ls -- MEM pipeline stage with sub-word loads/stores and data-memory wait states.
//
// The stage sits between EX/MEM and MEM/WB. It performs loads and stores on a local data
// memory, sign- or zero-extends sub-word loads, detects misaligned accesses, and passes
// branch and HI/LO results through one register stage.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   alu_out             ALU result / byte address
//   alu_out_bk          second (HI) result for HI/LO ops
//   xm_rd               destination register
//   xm_mem_ctr          op code (0 ALU, 1 LW, 2 SW, 3 LB, 4 LBU, 5 LH, 6 LHU, 7 SB, 8 SH, 9 HILO, 15 NOP)
//   xm_reg_to_mem       store data
//   xm_branch_ctr/addr  branch control and target
//   stall               combinational; high while an access is outstanding
//   mw_*                MEM/WB registers (mw_rd = 0 means no write)
//   branch_ctr/addr     registered branch fields, zero in bubble cycles
//   misalign            one-cycle pulse on a misaligned access
//
// FSM states:
//   S_IDLE | accepting a new op; non-memory ops and misaligned accesses complete here
//   S_WAIT | aligned access outstanding; completes when cnt_q reaches 0
module mem_stage_ls #(
    parameter int DATA_W   = 32,
    parameter int DM_DEPTH = 128,
    parameter int WAIT_CYC = 0,
    parameter int RD_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] alu_out_bk,
    input  logic [RD_W-1:0]   xm_rd,
    input  logic [3:0]        xm_mem_ctr,
    input  logic [DATA_W-1:0] xm_reg_to_mem,
    input  logic [2:0]        xm_branch_ctr,
    input  logic [DATA_W-1:0] xm_branch_addr,
    output logic              stall,
    output logic [DATA_W-1:0] mw_alu_out,
    output logic [DATA_W-1:0] mw_alu_out_bk,
    output logic [RD_W-1:0]   mw_rd,
    output logic [3:0]        mw_mem_ctr,
    output logic [2:0]        branch_ctr,
    output logic [DATA_W-1:0] branch_addr,
    output logic              misalign
);

    localparam int AW = $clog2(DM_DEPTH);

    localparam logic [3:0] OP_ALU  = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_SW   = 4'd2;
    localparam logic [3:0] OP_LB   = 4'd3;
    localparam logic [3:0] OP_LBU  = 4'd4;
    localparam logic [3:0] OP_LH   = 4'd5;
    localparam logic [3:0] OP_LHU  = 4'd6;
    localparam logic [3:0] OP_SB   = 4'd7;
    localparam logic [3:0] OP_SH   = 4'd8;
    localparam logic [3:0] OP_HILO = 4'd9;
    localparam logic [3:0] OP_NOP  = 4'd15;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        complete;

    logic [DATA_W-1:0] mem_q [DM_DEPTH];

    logic [AW-1:0]     widx;
    logic [1:0]        off;
    logic              is_load, is_store, misal, access;
    logic [DATA_W-1:0] rd_word, load_data, wdata;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [3:0]        be;

    logic [DATA_W-1:0] mw_alu_out_q, mw_alu_out_bk_q, branch_addr_q;
    logic [RD_W-1:0]   mw_rd_q;
    logic [3:0]        mw_mem_ctr_q;
    logic [2:0]        branch_ctr_q;
    logic              misalign_q;

    assign widx = alu_out[AW+1:2];
    assign off  = alu_out[1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misal    = 1'b0;
        case (xm_mem_ctr)
            OP_LW:          begin is_load  = 1'b1; misal = (off != 2'b00); end
            OP_SW:          begin is_store = 1'b1; misal = (off != 2'b00); end
            OP_LB, OP_LBU:  is_load = 1'b1;
            OP_LH, OP_LHU:  begin is_load  = 1'b1; misal = off[0]; end
            OP_SB:          is_store = 1'b1;
            OP_SH:          begin is_store = 1'b1; misal = off[0]; end
            default:        ;
        endcase
    end

    assign access = (is_load || is_store) && !misal;

    // Read is combinational from the registered array, so a store completing on one edge
    // is visible to a load that completes on any later edge.
    assign rd_word = mem_q[widx];
    assign byte_v  = rd_word[{off, 3'b000} +: 8];
    assign half_v  = off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        case (xm_mem_ctr)
            OP_LB:   load_data = {{(DATA_W-8){byte_v[7]}}, byte_v};
            OP_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_v};
            OP_LH:   load_data = {{(DATA_W-16){half_v[15]}}, half_v};
            OP_LHU:  load_data = {{(DATA_W-16){1'b0}}, half_v};
            default: ;
        endcase
    end

    always_comb begin
        be    = 4'b1111;
        wdata = xm_reg_to_mem;
        case (xm_mem_ctr)
            OP_SB: begin
                be    = 4'b0001 << off;
                wdata = {4{xm_reg_to_mem[7:0]}};
            end
            OP_SH: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{xm_reg_to_mem[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access && (WAIT_CYC > 0)) begin
                    state_d = S_WAIT;
                    cnt_d   = 3'(WAIT_CYC - 1);
                    stall   = 1'b1;
                end else begin
                    complete = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory contents survive reset; rst only suppresses a pending write.
    always_ff @(posedge clk) begin
        if (!rst && complete && is_store && !misal) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mw_alu_out_q    <= '0;
            mw_alu_out_bk_q <= '0;
            mw_rd_q         <= '0;
            mw_mem_ctr_q    <= '0;
            branch_ctr_q    <= '0;
            branch_addr_q   <= '0;
            misalign_q      <= 1'b0;
        end else if (complete) begin
            mw_alu_out_q    <= (is_load && !misal) ? load_data : alu_out;
            mw_alu_out_bk_q <= alu_out_bk;
            mw_rd_q         <= (xm_mem_ctr == OP_ALU || xm_mem_ctr == OP_HILO ||
                                (is_load && !misal)) ? xm_rd : '0;
            mw_mem_ctr_q    <= xm_mem_ctr;
            branch_ctr_q    <= xm_branch_ctr;
            branch_addr_q   <= xm_branch_addr;
            misalign_q      <= misal;
        end else begin
            // Bubble while stalled: nothing retires and the branch is not re-issued.
            mw_rd_q         <= '0;
            mw_mem_ctr_q    <= OP_NOP;
            branch_ctr_q    <= '0;
            branch_addr_q   <= '0;
            misalign_q      <= 1'b0;
        end
    end

    assign mw_alu_out    = mw_alu_out_q;
    assign mw_alu_out_bk = mw_alu_out_bk_q;
    assign mw_rd         = mw_rd_q;
    assign mw_mem_ctr    = mw_mem_ctr_q;
    assign branch_ctr    = branch_ctr_q;
    assign branch_addr   = branch_addr_q;
    assign misalign      = misalign_q;

endmodule

// File: tb/tb_mem_stage_ls.sv
module tb_mem_stage_ls;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out, alu_out_bk, xm_reg_to_mem, xm_branch_addr;
    logic [4:0]  xm_rd;
    logic [3:0]  xm_mem_ctr;
    logic [2:0]  xm_branch_ctr;

    logic        s0_stall, s0_mis, s3_stall, s3_mis;
    logic [31:0] s0_out, s0_bk, s0_baddr, s3_out, s3_bk, s3_baddr;
    logic [4:0]  s0_rd, s3_rd;
    logic [3:0]  s0_ctr, s3_ctr;
    logic [2:0]  s0_bctr, s3_bctr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_ls #(.DATA_W(32), .DM_DEPTH(128), .WAIT_CYC(0), .RD_W(5)) dut0 (
        .clk(clk), .rst(rst), .alu_out(alu_out), .alu_out_bk(alu_out_bk), .xm_rd(xm_rd),
        .xm_mem_ctr(xm_mem_ctr), .xm_reg_to_mem(xm_reg_to_mem), .xm_branch_ctr(xm_branch_ctr),
        .xm_branch_addr(xm_branch_addr), .stall(s0_stall), .mw_alu_out(s0_out),
        .mw_alu_out_bk(s0_bk), .mw_rd(s0_rd), .mw_mem_ctr(s0_ctr), .branch_ctr(s0_bctr),
        .branch_addr(s0_baddr), .misalign(s0_mis));

    mem_stage_ls #(.DATA_W(32), .DM_DEPTH(128), .WAIT_CYC(3), .RD_W(5)) dut3 (
        .clk(clk), .rst(rst), .alu_out(alu_out), .alu_out_bk(alu_out_bk), .xm_rd(xm_rd),
        .xm_mem_ctr(xm_mem_ctr), .xm_reg_to_mem(xm_reg_to_mem), .xm_branch_ctr(xm_branch_ctr),
        .xm_branch_addr(xm_branch_addr), .stall(s3_stall), .mw_alu_out(s3_out),
        .mw_alu_out_bk(s3_bk), .mw_rd(s3_rd), .mw_mem_ctr(s3_ctr), .branch_ctr(s3_bctr),
        .branch_addr(s3_baddr), .misalign(s3_mis));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        xm_mem_ctr     = op;
        alu_out        = addr;
        xm_reg_to_mem  = wd;
        xm_rd          = rd;
        alu_out_bk     = 32'h0;
        xm_branch_ctr  = 3'd0;
        xm_branch_addr = 32'h0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'd15, 32'h0, 32'h0, 5'd0);
        step(); step();
        total++; if (s0_out !== 32'h0) begin bad++; $display("FAIL reset_out: got %h want %h", s0_out, 32'h0); end
        total++; if (s0_rd !== 5'd0) begin bad++; $display("FAIL reset_rd: got %h want %h", s0_rd, 5'd0); end
        total++; if (s0_ctr !== 4'd0) begin bad++; $display("FAIL reset_ctr: got %h want %h", s0_ctr, 4'd0); end
        total++; if (s0_mis !== 1'b0 || s0_bctr !== 3'd0) begin bad++; $display("FAIL reset_mis_bctr: got %b/%h want 0/0", s0_mis, s0_bctr); end
        total++; if (s3_stall !== 1'b0) begin bad++; $display("FAIL reset_stall3: got %b want 0", s3_stall); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_word();
        drive(4'd2, 32'h10, 32'hDEADBEEF, 5'd7);
        total++; if (s0_stall !== 1'b0) begin bad++; $display("FAIL sw_stall0: got %b want 0", s0_stall); end
        step();
        total++; if (s0_rd !== 5'd0) begin bad++; $display("FAIL sw_rd: got %h want %h", s0_rd, 5'd0); end
        drive(4'd1, 32'h10, 32'h0, 5'd9);
        total++; if (s0_stall !== 1'b0) begin bad++; $display("FAIL lw_stall0: got %b want 0", s0_stall); end
        step();
        total++; if (s0_out !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_word: got %h want %h", s0_out, 32'hDEADBEEF); end
        total++; if (s0_rd !== 5'd9) begin bad++; $display("FAIL lw_rd: got %h want %h", s0_rd, 5'd9); end
    endtask

    task automatic test_subword_loads();
        drive(4'd2, 32'h10, 32'h80FF7F01, 5'd0); step();
        drive(4'd3, 32'h13, 32'h0, 5'd1); step();
        total++; if (s0_out !== 32'hFFFFFF80) begin bad++; $display("FAIL lb: got %h want %h", s0_out, 32'hFFFFFF80); end
        drive(4'd4, 32'h13, 32'h0, 5'd1); step();
        total++; if (s0_out !== 32'h00000080) begin bad++; $display("FAIL lbu: got %h want %h", s0_out, 32'h00000080); end
        drive(4'd5, 32'h12, 32'h0, 5'd1); step();
        total++; if (s0_out !== 32'hFFFF80FF) begin bad++; $display("FAIL lh: got %h want %h", s0_out, 32'hFFFF80FF); end
        drive(4'd6, 32'h10, 32'h0, 5'd1); step();
        total++; if (s0_out !== 32'h00007F01) begin bad++; $display("FAIL lhu: got %h want %h", s0_out, 32'h00007F01); end
        drive(4'd3, 32'h10, 32'h0, 5'd1); step();
        total++; if (s0_out !== 32'h00000001) begin bad++; $display("FAIL lb_off0: got %h want %h", s0_out, 32'h00000001); end
    endtask

    task automatic test_subword_stores();
        drive(4'd2, 32'h10, 32'h11223344, 5'd0); step();
        drive(4'd7, 32'h11, 32'h123456AA, 5'd3); step();
        total++; if (s0_rd !== 5'd0) begin bad++; $display("FAIL sb_rd: got %h want %h", s0_rd, 5'd0); end
        drive(4'd1, 32'h10, 32'h0, 5'd2); step();
        total++; if (s0_out !== 32'h1122AA44) begin bad++; $display("FAIL sb_lane: got %h want %h", s0_out, 32'h1122AA44); end
        drive(4'd8, 32'h12, 32'h5555BEEF, 5'd0); step();
        drive(4'd1, 32'h10, 32'h0, 5'd2); step();
        total++; if (s0_out !== 32'hBEEFAA44) begin bad++; $display("FAIL sh_lane: got %h want %h", s0_out, 32'hBEEFAA44); end
    endtask

    task automatic test_misalign();
        drive(4'd2, 32'h04, 32'h01020304, 5'd0); step();
        drive(4'd2, 32'h00, 32'hCAFEF00D, 5'd0); step();
        drive(4'd1, 32'h06, 32'h0, 5'd5);
        total++; if (s0_stall !== 1'b0) begin bad++; $display("FAIL mis_lw_stall: got %b want 0", s0_stall); end
        step();
        total++; if (s0_mis !== 1'b1 || s0_rd !== 5'd0) begin bad++; $display("FAIL mis_lw: got mis=%b rd=%h want 1/00", s0_mis, s0_rd); end
        drive(4'd15, 32'h0, 32'h0, 5'd6); step();
        total++; if (s0_mis !== 1'b0 || s0_rd !== 5'd0) begin bad++; $display("FAIL mis_pulse_nop: got mis=%b rd=%h want 0/00", s0_mis, s0_rd); end
        drive(4'd8, 32'h03, 32'h0000FFFF, 5'd0); step();
        total++; if (s0_mis !== 1'b1) begin bad++; $display("FAIL mis_sh: got %b want 1", s0_mis); end
        drive(4'd1, 32'h00, 32'h0, 5'd8); step();
        total++; if (s0_out !== 32'hCAFEF00D || s0_mis !== 1'b0) begin bad++; $display("FAIL mis_sh_nowrite: got %h mis=%b want %h mis=0", s0_out, s0_mis, 32'hCAFEF00D); end
        drive(4'd1, 32'h04, 32'h0, 5'd8); step();
        total++; if (s0_out !== 32'h01020304) begin bad++; $display("FAIL mis_lw_word: got %h want %h", s0_out, 32'h01020304); end
    endtask

    task automatic test_alias_hilo_branch();
        drive(4'd2, 32'h210, 32'h5A5A1234, 5'd0); step();
        drive(4'd1, 32'h010, 32'h0, 5'd4); step();
        total++; if (s0_out !== 32'h5A5A1234) begin bad++; $display("FAIL alias: got %h want %h", s0_out, 32'h5A5A1234); end
        drive(4'd9, 32'h12345678, 32'h0, 5'd3);
        alu_out_bk = 32'h9ABCDEF0;
        step();
        total++; if (s0_out !== 32'h12345678 || s0_bk !== 32'h9ABCDEF0) begin bad++; $display("FAIL hilo: got %h/%h want 12345678/9abcdef0", s0_out, s0_bk); end
        total++; if (s0_rd !== 5'd3 || s0_ctr !== 4'd9) begin bad++; $display("FAIL hilo_rd: got rd=%h ctr=%h want 03/9", s0_rd, s0_ctr); end
        drive(4'd0, 32'h00000042, 32'h0, 5'd11);
        xm_branch_ctr  = 3'd5;
        xm_branch_addr = 32'h00000400;
        step();
        total++; if (s0_bctr !== 3'd5 || s0_baddr !== 32'h400) begin bad++; $display("FAIL branch: got %h/%h want 5/00000400", s0_bctr, s0_baddr); end
        total++; if (s0_out !== 32'h42 || s0_rd !== 5'd11) begin bad++; $display("FAIL alu_wb: got %h/%h want 00000042/0b", s0_out, s0_rd); end
        drive(4'd12, 32'h0, 32'h0, 5'd11); step();
        total++; if (s0_bctr !== 3'd0 || s0_rd !== 5'd0) begin bad++; $display("FAIL op12_nop: got bctr=%h rd=%h want 0/00", s0_bctr, s0_rd); end
    endtask

    task automatic test_wait_states();
        int stalls;
        drive(4'd2, 32'h10, 32'h13572468, 5'd0);
        stalls = 0;
        for (int c = 0; c < 8 && s3_stall; c++) begin
            stalls++;
            step();
        end
        total++; if (stalls != 3) begin bad++; $display("FAIL wait_sw_stalls: got %0d want 3", stalls); end
        step();
        total++; if (s3_ctr !== 4'd2) begin bad++; $display("FAIL wait_sw_done: got %h want 2", s3_ctr); end
        drive(4'd1, 32'h10, 32'h0, 5'd12);
        xm_branch_ctr = 3'd6;
        #1;
        for (int c = 0; c < 4; c++) begin
            total++; if (s3_stall !== (c < 3)) begin bad++; $display("FAIL wait_lw_stall%0d: got %b want %b", c, s3_stall, (c < 3)); end
            step();
            if (c < 3) begin
                total++; if (s3_rd !== 5'd0 || s3_ctr !== 4'd15 || s3_bctr !== 3'd0) begin bad++; $display("FAIL wait_lw_bubble%0d: got rd=%h ctr=%h bctr=%h want 00/f/0", c, s3_rd, s3_ctr, s3_bctr); end
            end
        end
        total++; if (s3_rd !== 5'd12 || s3_out !== 32'h13572468) begin bad++; $display("FAIL wait_lw_result: got rd=%h out=%h want 0c/13572468", s3_rd, s3_out); end
        total++; if (s3_bctr !== 3'd6) begin bad++; $display("FAIL wait_branch_once: got %h want 6", s3_bctr); end
        drive(4'd15, 32'h0, 32'h0, 5'd0); step();
        total++; if (s3_bctr !== 3'd0) begin bad++; $display("FAIL wait_branch_clear: got %h want 0", s3_bctr); end
    endtask

    task automatic test_reset_in_flight();
        drive(4'd2, 32'h10, 32'hFFFFFFFF, 5'd0);
        step(); step();
        total++; if (s3_stall !== 1'b1) begin bad++; $display("FAIL rif_stall_before: got %b want 1", s3_stall); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(4'd15, 32'h0, 32'h0, 5'd0);
        total++; if (s3_stall !== 1'b0 || s3_rd !== 5'd0) begin bad++; $display("FAIL rif_stall_after: got stall=%b rd=%h want 0/00", s3_stall, s3_rd); end
        step();
        drive(4'd1, 32'h10, 32'h0, 5'd4);
        for (int c = 0; c < 4; c++) step();
        total++; if (s3_out !== 32'h13572468) begin bad++; $display("FAIL rif_mem_kept: got %h want %h", s3_out, 32'h13572468); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_loads();
        test_subword_stores();
        test_misalign();
        test_alias_hilo_branch();
        test_reset();
        test_wait_states();
        test_reset_in_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
